dvi_video_capture: RTL
======================

// Module: dvi_video_capture
// PURPOSE
//  Receive-side counterpart of the DVI output path. Samples a parallel video bus
//  (pixel clock, vsync, hsync, de, RGB565), expands it to RGB888, and tags each pixel
//  with x/y coordinates. Measures active width/height and asserts lock only after
//  LOCK_FRAMES consecutive identical frames. Feeds the capture/overlay pipeline.
// PARAMETERS
//  X_W          12  width of x counter / measured active width
//  Y_W          12  width of y counter / measured active height
//  LOCK_FRAMES  2   consecutive matching frames required to lock (1..15)
//  VSYNC_ACTIVE 1   vsync asserted level (1 = active-high, 0 = active-low)
// PORTS
//  pixel_clk_in  in   1    pixel clock; all logic on rising edge
//  rst           in   1    synchronous reset, active-high
//  vsync_in      in   1    vertical sync, polarity per VSYNC_ACTIVE
//  hsync_in      in   1    horizontal sync (pass-through only)
//  de_in         in   1    data enable; high = active pixel
//  pixel_r_in    in   5    red
//  pixel_g_in    in   6    green
//  pixel_b_in    in   5    blue
//  pixel_valid_o out  1    active pixel present and locked
//  pixel_r_o/g_o/b_o out 8 each  expanded colour
//  pixel_x_o     out  X_W  column of current pixel
//  pixel_y_o     out  Y_W  row of current pixel
//  sof_o         out  1    pulse with pixel (0,0) of a locked frame
//  eol_o         out  1    pulse with last pixel of each locked line
//  hsync_o/vsync_o out 1   syncs delayed to align with pixel outputs
//  locked_o      out  1    timing locked
//  h_active_o    out  X_W  measured active width (valid when locked_o)
//  v_active_o    out  Y_W  measured active height (valid when locked_o)
// BEHAVIOUR
//  - Reset: all outputs 0, FSM in SEARCH, counters/match count cleared.
//  - Stage 1 registers all inputs; stage 2 drives outputs: latency 2 cycles input->output.
//  - Expansion: r8={r5,r5[4:2]}, g8={g6,g6[5:4]}, b8={b5,b5[4:2]}; 0x1F->0xFF, 0->0x00.
//  - Frame start = stage-1 vsync transition into its active level (VSYNC_ACTIVE).
//    Clears x, y, line-width register and frame "consistent" flag set to 1.
//  - x increments each de-high cycle; de falling edge ends a line: line width = x,
//    x<=0, y<=y+1. First line of a frame sets the reference width; any later line
//    with different width clears "consistent". x or y at all-ones saturates and
//    clears "consistent".
//  - FSM SEARCH: wait frame start -> MEASURE (match_cnt=0).
//    MEASURE, at each frame start: if prev frame consistent, height>0, and width/height
//    equal stored values -> match_cnt++, else store new values, match_cnt=0.
//    match_cnt reaching LOCK_FRAMES-1 on a match -> LOCKED (locked_o=1 from next cycle).
//    LOCKED: any line width mismatch, saturation, or frame height mismatch at frame
//    start -> SEARCH; locked_o and pixel_valid_o drop the following cycle.
//  - Frames with zero active lines never count as a match.
//  - pixel_valid_o = stage-2 de AND locked; sof_o/eol_o gated the same way;
//    eol_o when x == h_active_o-1.
//  - vsync edge with de high same cycle: frame start processed first; pixel is (0,0).
//  - rst mid-frame: immediate return to reset state; relock needs full sequence.
// STRUCTURE
//  - video_pkg: X_W/Y_W defaults, FSM state enum {SEARCH,MEASURE,LOCKED},
//    rgb565_to_888 expansion function.
//  - Sub-module dvi_timing_meas: x/y counters, line-width/height measurement and
//    consistency flag; top holds input/output registers and lock FSM.
// TESTING
//  - 8x4 active frames, LOCK_FRAMES=2: locked_o=1 after 3rd frame start; h_active=8, v_active=4.
//  - Locked, pixel r5=1F g6=00 b5=10 -> r=FF g=00 b=84, 2 cycles later, valid=1.
//  - Locked, one line of width 7 mid-frame -> locked_o=0 next cycle, valid stays 0.
//  - Alternate 8x4 and 8x5 frames -> locked_o never asserts.
//  - Locked 8x4: sof_o with x=0,y=0; eol_o with x=7 on every line, 4 per frame.
//  - rst asserted mid-line -> all outputs 0 next cycle; relock after 2 more frames.

Source files
------------

// File: rtl/video_pkg.sv
// ============================================================================
// Module   : video_pkg
// Brief    : Shared widths, lock FSM states and RGB565->RGB888 expansion.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package video_pkg;

    localparam int c_x_w_default = 12;
    localparam int c_y_w_default = 12;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } lock_state_t;

    // Top bits are replicated into the LSBs so full-scale maps to 0xFF.
    function automatic logic [23:0] rgb565_to_888(input logic [4:0] r5,
                                                  input logic [5:0] g6,
                                                  input logic [4:0] b5);
        return {r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/dvi_timing_meas.sv
// ============================================================================
// Module   : dvi_timing_meas
// Brief    : Pixel x/y counters, per-frame width/height measurement and
//            frame consistency tracking on the registered video stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dvi_timing_meas #(
    parameter int X_W          = 12,
    parameter int Y_W          = 12,
    parameter bit VSYNC_ACTIVE = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           vsync,
    input  logic           de,
    output logic           frame_start,
    output logic           line_end,
    output logic           sat,
    output logic [X_W-1:0] px_x,
    output logic [Y_W-1:0] px_y,
    output logic [X_W-1:0] line_w,
    output logic [X_W-1:0] ref_w,
    output logic [Y_W-1:0] lines,
    output logic           consistent
);

    logic           r_vsync_d;
    logic           r_de_d;
    logic [X_W-1:0] r_x;
    logic [Y_W-1:0] r_y;
    logic [X_W-1:0] r_ref_w;
    logic           r_have_ref;
    logic           r_consistent;
    logic           w_x_full;
    logic           w_y_full;

    assign w_x_full    = &r_x;
    assign w_y_full    = &r_y;
    assign frame_start = (vsync == VSYNC_ACTIVE) && (r_vsync_d != VSYNC_ACTIVE);
    assign line_end    = !frame_start && r_de_d && !de;
    assign sat         = !frame_start && ((de && w_x_full) || (line_end && w_y_full));

    // A pixel coincident with frame start belongs to the new frame at (0,0).
    assign px_x       = frame_start ? '0 : r_x;
    assign px_y       = frame_start ? '0 : r_y;
    assign line_w     = r_x;
    assign ref_w      = r_ref_w;
    assign lines      = r_y;
    assign consistent = r_consistent;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vsync_d    <= !VSYNC_ACTIVE;
            r_de_d       <= 1'b0;
            r_x          <= '0;
            r_y          <= '0;
            r_ref_w      <= '0;
            r_have_ref   <= 1'b0;
            r_consistent <= 1'b0;
        end else begin
            r_vsync_d <= vsync;
            r_de_d    <= de;
            if (frame_start) begin
                r_x          <= {{(X_W-1){1'b0}}, de};
                r_y          <= '0;
                r_ref_w      <= '0;
                r_have_ref   <= 1'b0;
                r_consistent <= 1'b1;
            end else begin
                if (sat) begin
                    r_consistent <= 1'b0;
                end
                if (de) begin
                    if (!w_x_full) begin
                        r_x <= r_x + 1'b1;
                    end
                end else if (line_end) begin
                    r_x <= '0;
                    if (!w_y_full) begin
                        r_y <= r_y + 1'b1;
                    end
                    if (!r_have_ref) begin
                        r_ref_w    <= r_x;
                        r_have_ref <= 1'b1;
                    end else if (r_x != r_ref_w) begin
                        r_consistent <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/dvi_video_capture.sv
// ============================================================================
// Module   : dvi_video_capture
// Brief    : Parallel RGB565 video receiver: two-stage capture pipeline,
//            RGB888 expansion, x/y tagging and frame-timing lock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dvi_video_capture
    import video_pkg::*;
#(
    parameter int X_W          = c_x_w_default,
    parameter int Y_W          = c_y_w_default,
    parameter int LOCK_FRAMES  = 2,
    parameter bit VSYNC_ACTIVE = 1'b1
) (
    input  logic           pixel_clk_in,
    input  logic           rst,
    input  logic           vsync_in,
    input  logic           hsync_in,
    input  logic           de_in,
    input  logic [4:0]     pixel_r_in,
    input  logic [5:0]     pixel_g_in,
    input  logic [4:0]     pixel_b_in,
    output logic           pixel_valid_o,
    output logic [7:0]     pixel_r_o,
    output logic [7:0]     pixel_g_o,
    output logic [7:0]     pixel_b_o,
    output logic [X_W-1:0] pixel_x_o,
    output logic [Y_W-1:0] pixel_y_o,
    output logic           sof_o,
    output logic           eol_o,
    output logic           hsync_o,
    output logic           vsync_o,
    output logic           locked_o,
    output logic [X_W-1:0] h_active_o,
    output logic [Y_W-1:0] v_active_o
);

    logic r_s1_vsync, r_s1_hsync, r_s1_de;
    logic [4:0] r_s1_r;
    logic [5:0] r_s1_g;
    logic [4:0] r_s1_b;

    logic r_s2_de, r_s2_sof, r_s2_eol;

    logic           w_fs, w_line_end, w_sat, w_consistent;
    logic [X_W-1:0] w_px_x, w_line_w, w_ref_w;
    logic [Y_W-1:0] w_px_y, w_lines;

    lock_state_t    r_state, w_state_nxt;
    logic [3:0]     r_match_cnt, w_match_cnt_nxt;
    logic [4:0]     w_cnt_inc;
    logic [X_W-1:0] r_h_active, w_h_active_nxt;
    logic [Y_W-1:0] r_v_active, w_v_active_nxt;
    logic           w_frame_match;
    logic           w_locked;

    dvi_timing_meas #(
        .X_W          (X_W),
        .Y_W          (Y_W),
        .VSYNC_ACTIVE (VSYNC_ACTIVE)
    ) u_meas (
        .clk         (pixel_clk_in),
        .rst         (rst),
        .vsync       (r_s1_vsync),
        .de          (r_s1_de),
        .frame_start (w_fs),
        .line_end    (w_line_end),
        .sat         (w_sat),
        .px_x        (w_px_x),
        .px_y        (w_px_y),
        .line_w      (w_line_w),
        .ref_w       (w_ref_w),
        .lines       (w_lines),
        .consistent  (w_consistent)
    );

    assign w_frame_match = w_consistent && (w_lines != '0) &&
                           (w_ref_w == r_h_active) && (w_lines == r_v_active);
    assign w_cnt_inc     = {1'b0, r_match_cnt} + 5'd1;

    always_comb begin
        w_state_nxt     = r_state;
        w_match_cnt_nxt = r_match_cnt;
        w_h_active_nxt  = r_h_active;
        w_v_active_nxt  = r_v_active;
        unique case (r_state)
            SEARCH: begin
                // Stored timing is discarded so a relock always re-measures.
                if (w_fs) begin
                    w_state_nxt     = MEASURE;
                    w_match_cnt_nxt = '0;
                    w_h_active_nxt  = '0;
                    w_v_active_nxt  = '0;
                end
            end
            MEASURE: begin
                if (w_fs) begin
                    if (w_frame_match) begin
                        if (w_cnt_inc >= 5'(LOCK_FRAMES - 1)) begin
                            w_state_nxt = LOCKED;
                        end else begin
                            w_match_cnt_nxt = w_cnt_inc[3:0];
                        end
                    end else begin
                        w_h_active_nxt  = w_ref_w;
                        w_v_active_nxt  = w_lines;
                        w_match_cnt_nxt = '0;
                    end
                end
            end
            LOCKED: begin
                if ((w_fs && !w_frame_match) || w_sat ||
                    (w_line_end && (w_line_w != r_h_active))) begin
                    w_state_nxt = SEARCH;
                end
            end
            default: w_state_nxt = SEARCH;
        endcase
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst) begin
            r_state     <= SEARCH;
            r_match_cnt <= '0;
            r_h_active  <= '0;
            r_v_active  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_match_cnt <= w_match_cnt_nxt;
            r_h_active  <= w_h_active_nxt;
            r_v_active  <= w_v_active_nxt;
        end
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst) begin
            r_s1_vsync <= !VSYNC_ACTIVE;
            r_s1_hsync <= 1'b0;
            r_s1_de    <= 1'b0;
            r_s1_r     <= '0;
            r_s1_g     <= '0;
            r_s1_b     <= '0;
            r_s2_de    <= 1'b0;
            r_s2_sof   <= 1'b0;
            r_s2_eol   <= 1'b0;
            hsync_o    <= 1'b0;
            vsync_o    <= 1'b0;
            pixel_r_o  <= '0;
            pixel_g_o  <= '0;
            pixel_b_o  <= '0;
            pixel_x_o  <= '0;
            pixel_y_o  <= '0;
        end else begin
            r_s1_vsync <= vsync_in;
            r_s1_hsync <= hsync_in;
            r_s1_de    <= de_in;
            r_s1_r     <= pixel_r_in;
            r_s1_g     <= pixel_g_in;
            r_s1_b     <= pixel_b_in;
            r_s2_de    <= r_s1_de;
            r_s2_sof   <= r_s1_de && (w_px_x == '0) && (w_px_y == '0);
            r_s2_eol   <= r_s1_de && (w_px_x == r_h_active - 1'b1);
            hsync_o    <= r_s1_hsync;
            vsync_o    <= r_s1_vsync;
            {pixel_r_o, pixel_g_o, pixel_b_o} <= rgb565_to_888(r_s1_r, r_s1_g, r_s1_b);
            pixel_x_o  <= w_px_x;
            pixel_y_o  <= w_px_y;
        end
    end

    assign w_locked      = (r_state == LOCKED);
    assign locked_o      = w_locked;
    assign pixel_valid_o = r_s2_de && w_locked;
    assign sof_o         = r_s2_sof && w_locked;
    assign eol_o         = r_s2_eol && w_locked;
    assign h_active_o    = r_h_active;
    assign v_active_o    = r_v_active;

endmodule

`default_nettype wire
